// File: rtl/bcm_pkg.sv
// rtl/bcm_pkg.sv - shared types and helpers for the BCM frame scheduler
package bcm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_BLANK,
    S_LATCH,
    S_UNLATCH
  } state_e;

  function automatic logic [31:0] clamp(input logic [31:0] v, input logic [31:0] lo,
                                        input logic [31:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Wide enough for the largest LSB time shifted by the top bit plane.
  function automatic int on_time_width(input int lsb_max, input int depth_max);
    return $clog2(lsb_max) + depth_max;
  endfunction

endpackage

// File: rtl/bcm_on_timer.sv
// rtl/bcm_on_timer.sv - loadable down-counter with zero flag timing a plane's on-time
module bcm_on_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bcm_frame_scheduler.sv
// rtl/bcm_frame_scheduler.sv - walks (row, bit plane) of each frame, launching shifts and
// driving blank/latch/address so one plane is displayed while the next is shifted.
module bcm_frame_scheduler
  import bcm_pkg::*;
#(
  parameter int N_ROWS_MAX    = 64,
  parameter int BITDEPTH_MAX  = 8,
  parameter int LSB_BLANK_MAX = 200,
  parameter int TIMER_WIDTH   = on_time_width(LSB_BLANK_MAX, BITDEPTH_MAX)
) (
  input  logic                            clk,
  input  logic                            ctrl_rst_n,
  input  logic                            ctrl_en,
  input  logic [31:0]                     ctrl_n_rows,
  input  logic [31:0]                     ctrl_bitdepth,
  input  logic [31:0]                     ctrl_lsb_blank,
  input  logic                            ctrl_disp_buffer,
  output logic                            shift_go,
  input  logic                            shift_done,
  output logic [$clog2(N_ROWS_MAX)-2:0]   shift_row,
  output logic [$clog2(BITDEPTH_MAX)-1:0] shift_bit,
  output logic                            shift_buffer,
  output logic                            disp_blank,
  output logic                            disp_latch,
  output logic [4:0]                      disp_addr,
  output logic                            frame_start,
  output logic                            busy
);

  localparam int ROW_W = $clog2(N_ROWS_MAX) - 1;
  localparam int BIT_W = $clog2(BITDEPTH_MAX);
  localparam int LSB_W = $clog2(LSB_BLANK_MAX + 1);

  state_e            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic              buf_q, buf_d;
  logic [ROW_W-1:0]  rows_last_q, rows_last_d;
  logic [BIT_W-1:0]  bits_last_q, bits_last_d;
  logic [LSB_W-1:0]  lsb_q, lsb_d;
  logic              buf_s_q, buf_s_d;
  logic              go_q, go_d;
  logic              fs_q, fs_d;
  logic              blank_q, blank_d;
  logic              latch_q, latch_d;
  logic [4:0]        addr_q, addr_d;
  logic              seen_low_q, seen_low_d;
  logic              snapshot;
  logic              timer_load;
  logic              timer_zero;
  logic [TIMER_WIDTH-1:0] on_time;
  logic [TIMER_WIDTH-1:0] timer_val;
  logic              shift_complete;

  // Outputs are registered and so appear one cycle after the state that sets them;
  // the timer is preloaded one short so the unblanked window is exactly the on-time.
  always_comb begin
    on_time   = TIMER_WIDTH'(lsb_q) << bit_q;
    timer_val = (on_time == '0) ? '0 : on_time - TIMER_WIDTH'(1);
  end

  // Done must be seen low after the go before a high level counts as completion.
  assign shift_complete = seen_low_q && shift_done;

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    bit_d       = bit_q;
    buf_d       = buf_q;
    rows_last_d = rows_last_q;
    bits_last_d = bits_last_q;
    lsb_d       = lsb_q;
    buf_s_d     = buf_s_q;
    go_d        = 1'b0;
    fs_d        = 1'b0;
    blank_d     = blank_q;
    latch_d     = 1'b0;
    addr_d      = addr_q;
    snapshot    = 1'b0;
    timer_load  = 1'b0;

    case (state_q)
      S_IDLE: begin
        blank_d = 1'b1;
        if (ctrl_en) begin
          snapshot = 1'b1;
          state_d  = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        go_d    = 1'b1;
        fs_d    = 1'b1;
        row_d   = '0;
        bit_d   = '0;
        buf_d   = buf_s_q;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (shift_complete && timer_zero) begin
          blank_d = 1'b1;
          addr_d  = 5'(row_q);
          state_d = ctrl_en ? S_BLANK : S_IDLE;
        end
      end
      S_BLANK: begin
        blank_d = 1'b1;
        latch_d = 1'b1;
        state_d = S_LATCH;
      end
      S_LATCH: begin
        blank_d = 1'b1;
        state_d = S_UNLATCH;
      end
      S_UNLATCH: begin
        blank_d    = 1'b0;
        go_d       = 1'b1;
        timer_load = 1'b1;
        state_d    = S_WAIT;
        if (bit_q == bits_last_q) begin
          bit_d = '0;
          if (row_q == rows_last_q) begin
            row_d    = '0;
            snapshot = 1'b1;
            fs_d     = 1'b1;
            buf_d    = ctrl_disp_buffer;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end else begin
          bit_d = bit_q + BIT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (snapshot) begin
      rows_last_d = ROW_W'(clamp(ctrl_n_rows >> 1, 32'd1, 32'(N_ROWS_MAX / 2)) - 32'd1);
      bits_last_d = BIT_W'(clamp(ctrl_bitdepth, 32'd1, 32'(BITDEPTH_MAX)) - 32'd1);
      lsb_d       = LSB_W'(clamp(ctrl_lsb_blank, 32'd0, 32'(LSB_BLANK_MAX)));
      buf_s_d     = ctrl_disp_buffer;
    end

    seen_low_d = go_d ? 1'b0 : (seen_low_q || !shift_done);
  end

  always_ff @(posedge clk or negedge ctrl_rst_n) begin
    if (!ctrl_rst_n) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      bit_q       <= '0;
      buf_q       <= 1'b0;
      rows_last_q <= '0;
      bits_last_q <= '0;
      lsb_q       <= '0;
      buf_s_q     <= 1'b0;
      go_q        <= 1'b0;
      fs_q        <= 1'b0;
      blank_q     <= 1'b1;
      latch_q     <= 1'b0;
      addr_q      <= '0;
      seen_low_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      bit_q       <= bit_d;
      buf_q       <= buf_d;
      rows_last_q <= rows_last_d;
      bits_last_q <= bits_last_d;
      lsb_q       <= lsb_d;
      buf_s_q     <= buf_s_d;
      go_q        <= go_d;
      fs_q        <= fs_d;
      blank_q     <= blank_d;
      latch_q     <= latch_d;
      addr_q      <= addr_d;
      seen_low_q  <= seen_low_d;
    end
  end

  bcm_on_timer #(
    .WIDTH(TIMER_WIDTH)
  ) u_on_timer (
    .clk_i      (clk),
    .rst_ni     (ctrl_rst_n),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .zero_o     (timer_zero)
  );

  assign shift_go     = go_q;
  assign shift_row    = row_q;
  assign shift_bit    = bit_q;
  assign shift_buffer = buf_q;
  assign disp_blank   = blank_q;
  assign disp_latch   = latch_q;
  assign disp_addr    = addr_q;
  assign frame_start  = fs_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_bcm_frame_scheduler.sv
// tb/tb_bcm_frame_scheduler.sv - self-checking bench for bcm_frame_scheduler
module tb_bcm_frame_scheduler;

  logic        clk = 1'b0;
  logic        ctrl_rst_n = 1'b1;
  logic        ctrl_en = 1'b0;
  logic [31:0] ctrl_n_rows = 32'd4;
  logic [31:0] ctrl_bitdepth = 32'd2;
  logic [31:0] ctrl_lsb_blank = 32'd5;
  logic        ctrl_disp_buffer = 1'b0;
  logic        shift_done = 1'b1;
  logic        shift_go, shift_buffer, disp_blank, disp_latch, frame_start, busy;
  logic [4:0]  shift_row;
  logic [2:0]  shift_bit;
  logic [4:0]  disp_addr;

  always #5 clk = ~clk;

  bcm_frame_scheduler dut (
    .clk              (clk),
    .ctrl_rst_n       (ctrl_rst_n),
    .ctrl_en          (ctrl_en),
    .ctrl_n_rows      (ctrl_n_rows),
    .ctrl_bitdepth    (ctrl_bitdepth),
    .ctrl_lsb_blank   (ctrl_lsb_blank),
    .ctrl_disp_buffer (ctrl_disp_buffer),
    .shift_go         (shift_go),
    .shift_done       (shift_done),
    .shift_row        (shift_row),
    .shift_bit        (shift_bit),
    .shift_buffer     (shift_buffer),
    .disp_blank       (disp_blank),
    .disp_latch       (disp_latch),
    .disp_addr        (disp_addr),
    .frame_start      (frame_start),
    .busy             (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Shifter model plus observation queues, all in one negedge process so the
  // model's done update is visible to the sampling that follows it.
  int shift_delay = 2;
  int sh_cnt = 0;
  int cyc = 0;
  int rel_cyc = 0;
  int go_row[$], go_bit[$], go_buf[$], go_fs[$], go_cyc[$];
  int unblank_w[$], blank_w[$], latch_w[$], latch_cyc[$], latch_addr[$], done_cyc[$];
  int run_lo = 0, run_hi = 0, run_latch = 0;
  bit seen_unblank = 0;
  bit prev_done = 1;

  initial begin
    forever begin
      @(negedge clk);
      if (!ctrl_rst_n) begin
        shift_done = 1'b1;
        sh_cnt = 0;
      end else if (shift_go) begin
        shift_done = 1'b0;
        sh_cnt = shift_delay;
      end else if (sh_cnt > 0) begin
        sh_cnt--;
        if (sh_cnt == 0) shift_done = 1'b1;
      end
      cyc++;
      if (shift_go) begin
        go_row.push_back(int'(shift_row));
        go_bit.push_back(int'(shift_bit));
        go_buf.push_back(int'(shift_buffer));
        go_fs.push_back(int'(frame_start));
        go_cyc.push_back(cyc);
      end
      if (!disp_blank) begin
        if (run_hi > 0 && seen_unblank) blank_w.push_back(run_hi);
        run_hi = 0;
        run_lo++;
        seen_unblank = 1;
      end else begin
        if (run_lo > 0) unblank_w.push_back(run_lo);
        run_lo = 0;
        run_hi++;
      end
      if (disp_latch) begin
        if (run_latch == 0) begin
          latch_cyc.push_back(cyc);
          latch_addr.push_back(int'(disp_addr));
        end
        run_latch++;
      end else if (run_latch > 0) begin
        latch_w.push_back(run_latch);
        run_latch = 0;
      end
      if (shift_done && !prev_done) done_cyc.push_back(cyc);
      prev_done = shift_done;
    end
  end

  task automatic clear_mon();
    go_row.delete(); go_bit.delete(); go_buf.delete(); go_fs.delete(); go_cyc.delete();
    unblank_w.delete(); blank_w.delete(); latch_w.delete();
    latch_cyc.delete(); latch_addr.delete(); done_cyc.delete();
    run_lo = 0; run_hi = 0; run_latch = 0; seen_unblank = 0; prev_done = 1;
  endtask

  task automatic do_reset();
    #1 ctrl_rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 clear_mon();
    #1 ctrl_rst_n = 1'b1;
    rel_cyc = cyc;
  endtask

  // sel: 0 = shift_go count, 1 = unblank windows, 2 = latch pulses
  task automatic wait_count(input string name, input int sel, input int n, input int budget);
    int got;
    got = 0;
    for (int i = 0; i < budget; i++) begin
      got = (sel == 0) ? go_row.size() : (sel == 1) ? unblank_w.size() : latch_cyc.size();
      if (got >= n) break;
      @(posedge clk);
    end
    got = (sel == 0) ? go_row.size() : (sel == 1) ? unblank_w.size() : latch_cyc.size();
    check(name, (got >= n) ? n : got, n);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_go"},     int'(shift_go), 0);
    check({tag, "_row"},    int'(shift_row), 0);
    check({tag, "_bit"},    int'(shift_bit), 0);
    check({tag, "_buf"},    int'(shift_buffer), 0);
    check({tag, "_blank"},  int'(disp_blank), 1);
    check({tag, "_latch"},  int'(disp_latch), 0);
    check({tag, "_addr"},   int'(disp_addr), 0);
    check({tag, "_fstart"}, int'(frame_start), 0);
    check({tag, "_busy"},   int'(busy), 0);
  endtask

  function automatic int exp_width(input int on_time, input int delay);
    return (on_time > delay + 1) ? on_time : delay + 1;
  endfunction

  typedef struct {
    int n_rows;
    int bitdepth;
    int lsb;
    int exp_rows;
    int exp_bits;
    int exp_lsb;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, nl, n0;

    vecs[0] = '{n_rows: 4,   bitdepth: 2,  lsb: 5,   exp_rows: 2,  exp_bits: 2, exp_lsb: 5};
    vecs[1] = '{n_rows: 2,   bitdepth: 0,  lsb: 500, exp_rows: 1,  exp_bits: 1, exp_lsb: 200};
    vecs[2] = '{n_rows: 2,   bitdepth: 12, lsb: 0,   exp_rows: 1,  exp_bits: 8, exp_lsb: 0};
    vecs[3] = '{n_rows: 0,   bitdepth: 1,  lsb: 1,   exp_rows: 1,  exp_bits: 1, exp_lsb: 1};
    vecs[4] = '{n_rows: 200, bitdepth: 1,  lsb: 3,   exp_rows: 32, exp_bits: 1, exp_lsb: 3};
    vecs[5] = '{n_rows: 6,   bitdepth: 3,  lsb: 2,   exp_rows: 3,  exp_bits: 3, exp_lsb: 2};

    // Asynchronous reset values, sampled before any clock edge with reset low.
    #2 ctrl_rst_n = 1'b0;
    #1 check_reset_values("reset");

    // First launch latency and done-to-latch latency with a 10-cycle shifter.
    ctrl_en = 1'b1;
    shift_delay = 10;
    do_reset();
    wait_count("first_go_seen", 0, 1, 50);
    check("first_go_latency", go_cyc[0] - rel_cyc, 2);
    check("first_go_row", go_row[0], 0);
    check("first_go_bit", go_bit[0], 0);
    check("first_go_buf", go_buf[0], 0);
    check("first_go_fstart", go_fs[0], 1);
    wait_count("first_latch_seen", 2, 1, 50);
    check("done_to_latch", latch_cyc[0] - done_cyc[0], 2);

    // Table-driven frames with a fast shifter, including clamped configurations.
    for (int v = 0; v < 6; v++) begin
      ctrl_en = 1'b0;
      ctrl_n_rows = 32'(vecs[v].n_rows);
      ctrl_bitdepth = 32'(vecs[v].bitdepth);
      ctrl_lsb_blank = 32'(vecs[v].lsb);
      ctrl_disp_buffer = 1'b0;
      shift_delay = 2;
      do_reset();
      ctrl_en = 1'b1;
      p = vecs[v].exp_rows * vecs[v].exp_bits;
      wait_count($sformatf("v%0d_gos", v), 0, p + 1, 3000);
      wait_count($sformatf("v%0d_windows", v), 1, p, 3000);
      for (int k = 0; k <= p; k++) begin
        check($sformatf("v%0d_go%0d_row", v, k), go_row[k], (k % p) / vecs[v].exp_bits);
        check($sformatf("v%0d_go%0d_bit", v, k), go_bit[k], k % vecs[v].exp_bits);
        check($sformatf("v%0d_go%0d_fstart", v, k), go_fs[k], ((k % p) == 0) ? 1 : 0);
      end
      for (int k = 0; k < p; k++) begin
        check($sformatf("v%0d_plane%0d_unblank", v, k), unblank_w[k],
              exp_width(vecs[v].exp_lsb << (k % vecs[v].exp_bits), 2));
        check($sformatf("v%0d_plane%0d_addr", v, k), latch_addr[k], k / vecs[v].exp_bits);
      end
      foreach (blank_w[k]) check($sformatf("v%0d_blank_run%0d", v, k), blank_w[k], 3);
      foreach (latch_w[k]) check($sformatf("v%0d_latch_run%0d", v, k), latch_w[k], 1);
    end

    // Shifter slower than the on-time: display is held until done, latch follows done.
    ctrl_n_rows = 32'd2;
    ctrl_bitdepth = 32'd1;
    ctrl_lsb_blank = 32'd1;
    shift_delay = 50;
    do_reset();
    wait_count("slow_windows", 1, 2, 400);
    check("slow_unblank0", unblank_w[0], 51);
    check("slow_unblank1", unblank_w[1], 51);
    check("slow_done_to_latch0", latch_cyc[0] - done_cyc[0], 2);
    check("slow_done_to_latch1", latch_cyc[1] - done_cyc[1], 2);

    // Buffer and bitdepth changed mid-frame take effect only at the next frame.
    ctrl_n_rows = 32'd4;
    ctrl_bitdepth = 32'd2;
    ctrl_lsb_blank = 32'd5;
    ctrl_disp_buffer = 1'b0;
    shift_delay = 2;
    do_reset();
    wait_count("midframe_go1", 0, 2, 100);
    ctrl_disp_buffer = 1'b1;
    ctrl_bitdepth = 32'd1;
    wait_count("midframe_gos", 0, 6, 400);
    for (int k = 0; k < 4; k++) check($sformatf("midframe_buf%0d", k), go_buf[k], 0);
    check("midframe_bit3", go_bit[3], 1);
    check("midframe_buf4", go_buf[4], 1);
    check("midframe_fstart4", go_fs[4], 1);
    check("midframe_buf5", go_buf[5], 1);
    check("midframe_fstart5", go_fs[5], 0);
    check("midframe_row5", go_row[5], 1);
    check("midframe_bit5", go_bit[5], 0);

    // Disable: the sequencer finishes the plane in flight and parks blanked in IDLE.
    ctrl_en = 1'b0;
    for (int i = 0; i < 300 && busy; i++) @(posedge clk);
    #1 check("disable_busy", int'(busy), 0);
    nl = latch_cyc.size();
    repeat (20) @(posedge clk);
    #1 check("disable_no_latch", latch_cyc.size(), nl);
    check("disable_blank", int'(disp_blank), 1);

    // Reset pulsed while waiting on a slow shift of plane (0,1).
    ctrl_bitdepth = 32'd2;
    ctrl_disp_buffer = 1'b1;
    shift_delay = 50;
    n0 = go_row.size();
    ctrl_en = 1'b1;
    wait_count("midwait_gos", 0, n0 + 2, 200);
    check("midwait_bit_before", go_bit[n0 + 1], 1);
    repeat (10) @(posedge clk);
    #3 ctrl_rst_n = 1'b0;
    #1 check_reset_values("midwait");
    repeat (2) @(negedge clk);
    #1 clear_mon();
    #1 ctrl_rst_n = 1'b1;
    rel_cyc = cyc;
    wait_count("restart_go", 0, 1, 50);
    check("restart_latency", go_cyc[0] - rel_cyc, 2);
    check("restart_row", go_row[0], 0);
    check("restart_bit", go_bit[0], 0);
    check("restart_buf", go_buf[0], 1);
    check("restart_fstart", go_fs[0], 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
